// File: rtl/uart_pkt_pkg.sv
// Shared packet-format definitions for the host-bound UART packet link.
// The footer function is also used by the receive side to check packets.
package uart_pkt_pkg;

   localparam int LOC_W  = 10;
   localparam int DATA_W = 8;
   localparam int FTR_W  = 3;
   localparam int PKT_W  = 24;
   localparam logic [2:0] PKT_HDR = 3'b101;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_GAP
   } tx_state_t;

   function automatic logic [FTR_W-1:0] calc_footer(input logic [DATA_W-1:0] data,
                                                    input logic [LOC_W-1:0]  loc);
      calc_footer = {^data, ^loc, ^{data[7:4], loc[9:5]}};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a trailing idle gap. A start seen in the last gap
// cycle chains straight into the next start bit with no extra idle.
module uart_tx_byte
   import uart_pkt_pkg::*;
#(
   parameter int BIT_CYC = 160,
   parameter int GAP_CYC = 80
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       txd,
   output logic       done
);

   localparam int CNT_MAX = (BIT_CYC > GAP_CYC) ? BIT_CYC : GAP_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam bit NO_GAP = (GAP_CYC == 0);

   tx_state_t        state, state_nxt;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       sh, sh_nxt;
   logic             bit_end, gap_end, load;

   assign bit_end = (baud_cnt == BIT_LAST);
   assign gap_end = (baud_cnt == GAP_LAST);

   always_comb begin
      state_nxt = state;
      sh_nxt    = sh;
      load      = 1'b0;
      done      = 1'b0;
      case (state)
         TX_IDLE:  if (start) load = 1'b1;
         TX_START: if (bit_end) state_nxt = TX_DATA;
         TX_DATA: begin
            if (bit_end) begin
               sh_nxt = {1'b1, sh[7:1]};
               if (bit_cnt == 3'd7) state_nxt = TX_STOP;
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               if (NO_GAP) done = 1'b1;
               else        state_nxt = TX_GAP;
            end
         end
         TX_GAP:  if (gap_end) done = 1'b1;
         default: state_nxt = TX_IDLE;
      endcase
      if (done) begin
         state_nxt = TX_IDLE;
         load      = start;
      end
      if (load) begin
         state_nxt = TX_START;
         sh_nxt    = byte_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TX_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         sh       <= '0;
         txd      <= 1'b1;
      end else begin
         state <= state_nxt;
         sh    <= sh_nxt;
         if (state_nxt != state || (state == TX_DATA && bit_end))
            baud_cnt <= '0;
         else if (state != TX_IDLE)
            baud_cnt <= baud_cnt + 1'b1;
         if (state != TX_DATA)
            bit_cnt <= '0;
         else if (bit_end)
            bit_cnt <= bit_cnt + 1'b1;
         // Drive the line from next-state so it changes on the same edge as the FSM.
         case (state_nxt)
            TX_START: txd <= 1'b0;
            TX_DATA:  txd <= sh_nxt[0];
            default:  txd <= 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/uart_packet_tx.sv
// Host-bound packet transmitter: frames {hdr, loc, data, footer} into 24 bits
// and sends it as three 8N1 bytes, MSB byte first.
module uart_packet_tx
   import uart_pkt_pkg::*;
#(
   parameter int FREQ    = 50_000_000,
   parameter int BAUD    = 312_500,
   parameter int GAP_CYC = 80
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pkt_valid,
   output logic              pkt_ready,
   input  logic [LOC_W-1:0]  pkt_loc,
   input  logic [DATA_W-1:0] pkt_data,
   output logic              txd,
   output logic              busy,
   output logic              pkt_done
);

   localparam int BIT_CYC = FREQ / BAUD;

   logic [PKT_W-1:0] pkt_word;
   logic [15:0]      pkt_sr;    // bytes still to send after byte0
   logic [1:0]       byte_idx;
   logic             accept, byte_done, byte_start;
   logic [7:0]       byte_val;

   assign pkt_word   = {PKT_HDR, pkt_loc, pkt_data, calc_footer(pkt_data, pkt_loc)};
   assign pkt_ready  = ~busy;
   assign accept     = pkt_valid & pkt_ready;
   assign byte_start = accept | (byte_done && byte_idx != 2'd2);
   assign byte_val   = accept ? pkt_word[23:16] : pkt_sr[15:8];

   uart_tx_byte #(
      .BIT_CYC (BIT_CYC),
      .GAP_CYC (GAP_CYC)
   ) u_tx_byte (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (byte_start),
      .byte_in (byte_val),
      .txd     (txd),
      .done    (byte_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_sr   <= '0;
         byte_idx <= '0;
         busy     <= 1'b0;
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         if (accept) begin
            pkt_sr   <= pkt_word[15:0];
            byte_idx <= '0;
            busy     <= 1'b1;
         end else if (byte_done) begin
            if (byte_idx == 2'd2) begin
               byte_idx <= '0;
               busy     <= 1'b0;
               pkt_done <= 1'b1;
            end else begin
               pkt_sr   <= {pkt_sr[7:0], 8'h00};
               byte_idx <= byte_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: walks every cycle of each packet and checks
// the serial line against hand-computed frames at fixed offsets from accept.
module tb_uart_packet_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [9:0] pkt_loc = '0;
   logic [7:0] pkt_data = '0;
   logic       pkt_ready, txd, busy, pkt_done;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_packet_tx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .pkt_loc   (pkt_loc),
      .pkt_data  (pkt_data),
      .txd       (txd),
      .busy      (busy),
      .pkt_done  (pkt_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      vectors++;
      assert (obs === req) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
      end
   endtask

   function automatic logic [23:0] model_pkt(input logic [9:0] loc, input logic [7:0] d);
      logic [2:0] f;
      f = {^d, ^loc, ^{d[7:4], loc[9:5]}};
      return {3'b101, loc, d, f};
   endfunction

   // Called at a negedge with ready high; returns at offset 0 (first negedge after accept).
   task automatic send(input logic [9:0] loc, input logic [7:0] d, input bit hold);
      pkt_loc   = loc;
      pkt_data  = d;
      pkt_valid = 1'b1;
      @(negedge clk);
      if (!hold) begin
         pkt_valid = 1'b0;
         pkt_loc   = ~loc;
         pkt_data  = ~d;
      end
   endtask

   // From offset 0 to offset 5040 (the pkt_done cycle), checking the line.
   task automatic walk_pkt(input string tag, input logic [23:0] pkt, input int pulse_off);
      int bn, r, bi, pos;
      logic [7:0] b;
      logic e;
      chk({tag, " accept busy/ready"}, {30'd0, busy, pkt_ready}, 32'b10);
      for (int o = 0; o < 5040; o++) begin
         bn = o / 1680;
         r  = o % 1680;
         b  = pkt[23 - 8*bn -: 8];
         if (r < 1600) begin
            bi  = r / 160;
            pos = r % 160;
            if (pos == 0 || pos == 80 || pos == 159) begin
               e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
               chk($sformatf("%s byte%0d bit%0d pos%0d", tag, bn, bi, pos), {31'd0, txd}, {31'd0, e});
            end
         end else if (r == 1600 || r == 1679) begin
            chk($sformatf("%s byte%0d gap", tag, bn), {31'd0, txd}, 32'd1);
         end
         if (o == 5039)
            chk({tag, " pre-done"}, {30'd0, pkt_done, busy}, 32'b01);
         if (pulse_off >= 0 && o == pulse_off)          pkt_valid = 1'b1;
         else if (pulse_off >= 0 && o == pulse_off + 1) pkt_valid = 1'b0;
         @(negedge clk);
      end
      chk({tag, " done/busy/ready/txd"}, {28'd0, pkt_done, busy, pkt_ready, txd}, 32'b1011);
   endtask

   initial begin
      // 1: reset and idle
      repeat (3) @(negedge clk);
      chk("reset state", {28'd0, txd, pkt_ready, busy, pkt_done}, 32'b1100);
      rst_n = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         chk("idle", {28'd0, txd, pkt_ready, busy, pkt_done}, 32'b1100);
      end

      // 2: all-zero packet, done exactly 5040 cycles after accept
      send(10'd0, 8'h00, 1'b0);
      walk_pkt("t2", 24'hA00000, -1);
      @(negedge clk);
      chk("t2 done one-shot", {31'd0, pkt_done}, 32'd0);

      // 3: footer cases
      send(10'd5, 8'h3C, 1'b0);
      walk_pkt("t3a", 24'hA029E0, -1);
      send(10'd784, 8'hFF, 1'b0);
      walk_pkt("t3b", 24'hB887FA, -1);

      // 4: valid held across two packets, then a stray mid-packet pulse
      pkt_loc = 10'd5; pkt_data = 8'h3C; pkt_valid = 1'b1;
      @(negedge clk);
      pkt_loc = 10'd784; pkt_data = 8'hFF;
      walk_pkt("t4a", 24'hA029E0, -1);
      @(negedge clk);
      pkt_valid = 1'b0; pkt_loc = '0; pkt_data = '0;
      walk_pkt("t4b", 24'hB887FA, -1);
      @(negedge clk);
      send(10'd0, 8'h00, 1'b0);
      walk_pkt("t4c", 24'hA00000, 2500);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         chk("t4 no extra packet", {30'd0, txd, busy}, 32'b10);
      end

      // 5: reset mid byte1 aborts, next packet starts clean
      send(10'd5, 8'h3C, 1'b0);
      repeat (2080) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t5 async reset", {28'd0, txd, busy, pkt_ready, pkt_done}, 32'b1010);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5 idle after reset", {28'd0, txd, busy, pkt_ready, pkt_done}, 32'b1010);
      send(10'd784, 8'hFF, 1'b0);
      walk_pkt("t5", 24'hB887FA, -1);

      // 6: model-checked sample across the loc range
      @(negedge clk);
      send(10'd1, 8'h01, 1'b0);
      walk_pkt("t6 loc1", model_pkt(10'd1, 8'h01), -1);
      send(10'd392, 8'hA5, 1'b0);
      walk_pkt("t6 loc392", model_pkt(10'd392, 8'hA5), -1);
      send(10'd783, 8'h5A, 1'b0);
      walk_pkt("t6 loc783", model_pkt(10'd783, 8'h5A), -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
